// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES types, round-count constants, inverse S-box and GF(2^8) helpers
package aes_pkg;

  // Indexed [column][row]: byte r+4c of the 128-bit word, byte 0 in bits 127:120.
  typedef logic [0:3][0:3][7:0] state_t;

  typedef enum logic [1:0] {IDLE, ROUND, LAST, DONE} fsm_t;

  localparam int NR_128 = 10;
  localparam int NR_192 = 12;
  localparam int NR_256 = 14;

  localparam logic [1:0] KEY_LEN_128 = 2'b00;
  localparam logic [1:0] KEY_LEN_192 = 2'b01;
  localparam logic [1:0] KEY_LEN_256 = 2'b10;

  localparam logic [0:255][7:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return INV_SBOX[b];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

endpackage

// File: rtl/inv_round_comb.sv
// rtl/inv_round_comb.sv - one combinational inverse AES round; mix_en low gives the final round
module inv_round_comb
  import aes_pkg::*;
(
  input  state_t state,
  input  state_t key,
  input  logic   mix_en,
  output state_t result
);

  localparam logic [0:3][7:0] COEF = {8'h0e, 8'h0b, 8'h0d, 8'h09};

  state_t sub;
  state_t mix;

  always_comb begin
    sub = '0;
    mix = '0;
    // Row r rotates right by r, so the byte landing in column c came from column c-r.
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        sub[c][r] = inv_sbox(state[(c + 4 - r) % 4][r]) ^ key[c][r];
      end
    end
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        for (int j = 0; j < 4; j++) begin
          mix[c][r] = mix[c][r] ^ gmul(sub[c][j], COEF[(j + 4 - r) % 4]);
        end
      end
    end
    result = mix_en ? mix : sub;
  end

endmodule

// File: rtl/inv_cipher_iter.sv
// rtl/inv_cipher_iter.sv - iterative AES inverse cipher, one round per cycle, external round keys
module inv_cipher_iter
  import aes_pkg::*;
#(
  parameter int MAX_NR = 14,
  parameter int IDX_W  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [127:0]     in_data,
  input  logic [1:0]       key_len,
  output logic [IDX_W-1:0] key_idx,
  input  logic [127:0]     key_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [127:0]     out_data,
  output logic             out_err
);

  fsm_t             fsm_q, fsm_d;
  state_t           state_q, state_d, round_out;
  logic [IDX_W-1:0] rnd_q, rnd_d, nr_in;
  logic             err_q, err_d, err_in, accept;

  // Unsupported or illegal lengths still run a full 10-round job, flagged as an error.
  always_comb begin
    nr_in  = IDX_W'(NR_128);
    err_in = 1'b0;
    case (key_len)
      KEY_LEN_128: nr_in = IDX_W'(NR_128);
      KEY_LEN_192: if (MAX_NR >= NR_192) nr_in = IDX_W'(NR_192); else err_in = 1'b1;
      KEY_LEN_256: if (MAX_NR >= NR_256) nr_in = IDX_W'(NR_256); else err_in = 1'b1;
      default:     err_in = 1'b1;
    endcase
  end

  inv_round_comb u_round (
    .state  (state_q),
    .key    (key_data),
    .mix_en (fsm_q == ROUND),
    .result (round_out)
  );

  always_comb begin
    fsm_d     = fsm_q;
    state_d   = state_q;
    rnd_d     = rnd_q;
    err_d     = err_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    key_idx   = '0;
    case (fsm_q)
      IDLE: begin
        in_ready = 1'b1;
        key_idx  = nr_in;
      end
      ROUND: begin
        key_idx = rnd_q;
        state_d = round_out;
        rnd_d   = rnd_q - 1'b1;
        if (rnd_q == IDX_W'(1)) fsm_d = LAST;
      end
      LAST: begin
        state_d = round_out;
        fsm_d   = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          in_ready = 1'b1;
          fsm_d    = IDLE;
          if (in_valid) key_idx = nr_in;
        end
      end
      default: fsm_d = IDLE;
    endcase
    // A new job may start from IDLE or straight out of DONE with no bubble.
    accept = in_ready && in_valid;
    if (accept) begin
      state_d = state_t'(in_data ^ key_data);
      rnd_d   = nr_in - 1'b1;
      err_d   = err_in;
      fsm_d   = ROUND;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fsm_q   <= IDLE;
      state_q <= '0;
      rnd_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      rnd_q   <= rnd_d;
      err_q   <= err_d;
    end
  end

  assign out_data = state_q;
  assign out_err  = err_q;

endmodule

// File: tb/tb_inv_cipher_iter.sv
// tb/tb_inv_cipher_iter.sv - directed and randomized checks of inv_cipher_iter against a forward-cipher model
module tb_inv_cipher_iter;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic [1:0]   key_len;
  logic [3:0]   key_idx;
  logic [127:0] key_data;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic         out_err;

  logic [127:0] rk [0:15];
  logic [7:0]   sbox [256];
  int checks = 0;
  int errors = 0;

  localparam logic [255:0] K128 = 256'h000102030405060708090a0b0c0d0e0f_00000000000000000000000000000000;
  localparam logic [255:0] K192 = 256'h000102030405060708090a0b0c0d0e0f1011121314151617_0000000000000000;
  localparam logic [255:0] K256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] CT128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] PT    = 128'h00112233445566778899aabbccddeeff;

  always #5 clk = ~clk;

  assign key_data = rk[key_idx];

  inv_cipher_iter dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .key_len   (key_len),
    .key_idx   (key_idx),
    .key_data  (key_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_err   (out_err)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Carry-less product reduced modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = 16'h0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
    for (int i = 14; i >= 8; i--) if (p[i]) p = p ^ (16'h11b << (i - 8));
    return p[7:0];
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic int nr_of(input logic [1:0] kl);
    return (kl == 2'b01) ? 12 : (kl == 2'b10) ? 14 : 10;
  endfunction

  function automatic logic [31:0] subword(input logic [31:0] x);
    return {sbox[x[31:24]], sbox[x[23:16]], sbox[x[15:8]], sbox[x[7:0]]};
  endfunction

  task automatic load_keys(input logic [255:0] key, input logic [1:0] kl);
    logic [31:0] w [60];
    logic [31:0] temp;
    logic [7:0]  rcon;
    int nk, nr;
    nk = (kl == 2'b01) ? 6 : (kl == 2'b10) ? 8 : 4;
    nr = nk + 6;
    rcon = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = key[255 - 32 * i -: 32];
    for (int i = nk; i < 4 * (nr + 1); i++) begin
      temp = w[i - 1];
      if (i % nk == 0) begin
        temp = subword({temp[23:0], temp[31:24]}) ^ {rcon, 24'h0};
        rcon = gm(rcon, 8'h02);
      end else if (nk > 6 && i % nk == 4) begin
        temp = subword(temp);
      end
      w[i] = w[i - nk] ^ temp;
    end
    for (int k = 0; k < 16; k++) rk[k] = (k <= nr) ? {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]} : 128'h0;
  endtask

  function automatic logic [127:0] encrypt(input logic [127:0] pt, input int nr);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   a [4];
    logic [127:0] res;
    for (int i = 0; i < 16; i++) s[i] = pt[127 - 8 * i -: 8] ^ rk[0][127 - 8 * i -: 8];
    for (int rd = 1; rd <= nr; rd++) begin
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) t[r + 4 * c] = sbox[s[r + 4 * ((c + r) % 4)]];
      if (rd < nr) begin
        for (int c = 0; c < 4; c++) begin
          for (int r = 0; r < 4; r++) a[r] = t[r + 4 * c];
          for (int r = 0; r < 4; r++)
            t[r + 4 * c] = gm(a[r], 8'h02) ^ gm(a[(r + 1) % 4], 8'h03) ^ a[(r + 2) % 4] ^ a[(r + 3) % 4];
        end
      end
      for (int i = 0; i < 16; i++) s[i] = t[i] ^ rk[rd][127 - 8 * i -: 8];
    end
    for (int i = 0; i < 16; i++) res[127 - 8 * i -: 8] = s[i];
    return res;
  endfunction

  // Entered and left at a falling edge; the job is taken on the rising edge in between.
  task automatic accept_job(input logic [127:0] ct, input logic [1:0] kl, input logic [255:0] key);
    load_keys(key, kl);
    in_data  = ct;
    key_len  = kl;
    in_valid = 1'b1;
    #1;
    check("in_ready at accept", in_ready, 1);
    check("key_idx at accept", key_idx, nr_of(kl));
    @(posedge clk);
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_data   = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic await_result(input string tag, input logic [127:0] exp_pt, input logic exp_err, input int nr);
    int n;
    n = 1;
    while (out_valid !== 1'b1 && n <= 40) begin
      check({tag, " key_idx"}, key_idx, nr - n);
      @(negedge clk);
      n++;
    end
    check({tag, " latency"}, n, nr + 1);
    check({tag, " out_data"}, out_data, exp_pt);
    check({tag, " out_err"}, out_err, exp_err);
    check({tag, " key_idx done"}, key_idx, 0);
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    #1;
    check("in_ready on release", in_ready, 1);
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("out_valid after release", out_valid, 0);
    check("in_ready idle", in_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] key;
    logic [127:0] pt;
    logic [127:0] ct;
    logic [1:0]   kl;
    int           seen;
    int           hold;

    for (int k = 0; k < 16; k++) rk[k] = 128'h0;
    build_sbox();
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0; key_len = 2'b00;
    repeat (2) @(negedge clk);
    check("reset out_valid", out_valid, 0);
    check("reset out_data", out_data, 0);
    check("reset out_err", out_err, 0);
    rst = 1'b1;

    accept_job(CT128, 2'b00, K128);
    await_result("aes128", PT, 1'b0, 10);
    release_out();
    accept_job(CT192, 2'b01, K192);
    await_result("aes192", PT, 1'b0, 12);
    release_out();
    accept_job(CT256, 2'b10, K256);
    await_result("aes256", PT, 1'b0, 14);
    release_out();

    // Backpressure, with a stray offer that must be ignored, then a bubble-free second job.
    accept_job(CT128, 2'b00, K128);
    await_result("bp first", PT, 1'b0, 10);
    repeat (5) begin
      in_valid = 1'b1;
      in_data  = {$urandom, $urandom, $urandom, $urandom};
      #1;
      check("bp in_ready", in_ready, 0);
      check("bp out_valid", out_valid, 1);
      check("bp out_data", out_data, PT);
      @(negedge clk);
    end
    key = {$urandom, $urandom, $urandom, $urandom, 128'h0};
    pt  = {$urandom, $urandom, $urandom, $urandom};
    load_keys(key, 2'b00);
    ct = encrypt(pt, 10);
    out_ready = 1'b1;
    accept_job(ct, 2'b00, key);
    await_result("b2b second", pt, 1'b0, 10);
    release_out();

    // Reset dropped in cycle 5 of a job.
    accept_job(CT128, 2'b00, K128);
    repeat (4) @(negedge clk);
    rst = 1'b0;
    #1;
    check("midreset out_valid", out_valid, 0);
    check("midreset out_data", out_data, 0);
    check("midreset out_err", out_err, 0);
    @(negedge clk);
    rst = 1'b1;
    seen = 0;
    repeat (16) begin
      @(negedge clk);
      if (out_valid !== 1'b0) seen++;
    end
    check("midreset no output", seen, 0);
    check("midreset in_ready", in_ready, 1);
    accept_job(CT128, 2'b00, K128);
    await_result("after reset", PT, 1'b0, 10);
    release_out();

    accept_job(CT128, 2'b11, K128);
    await_result("illegal", PT, 1'b1, 10);
    release_out();

    for (int j = 0; j < 8; j++) begin
      kl  = 2'($urandom_range(0, 2));
      key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      pt  = {$urandom, $urandom, $urandom, $urandom};
      load_keys(key, kl);
      ct = encrypt(pt, nr_of(kl));
      accept_job(ct, kl, key);
      await_result("random", pt, 1'b0, nr_of(kl));
      hold = $urandom_range(0, 3);
      repeat (hold) begin
        @(negedge clk);
        check("random hold out_data", out_data, pt);
      end
      release_out();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/inv_cipher_iter.md
INV_CIPHER_ITER -- requirements
Module: inv_cipher_iter

Interface
REQ-001 SHALL have parameter MAX_NR, default 14, meaning the highest round count built in (legal values 10, 12, 14).
REQ-002 SHALL have parameter IDX_W, default 4, meaning the round-key index width.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset; asynchronous, active-low.
REQ-005 SHALL have port in_valid, input, 1: a ciphertext is offered.
REQ-006 SHALL have port in_ready, output, 1: the block accepts a ciphertext this cycle.
REQ-007 SHALL have port in_data, input, 128: ciphertext; in_data[127:120] is byte 0, and state[r][c] = byte r+4c.
REQ-008 SHALL have port key_len, input, 2: 00 = 10 rounds, 01 = 12 rounds, 10 = 14 rounds, 11 = illegal; sampled on accept.
REQ-009 SHALL have port key_idx, output, IDX_W: index of the round key required this cycle.
REQ-010 SHALL have port key_data, input, 128: round key key_idx, supplied combinationally in the same cycle, with the same byte order as in_data.
REQ-011 SHALL have port out_valid, output, 1: a result is held.
REQ-012 SHALL have port out_ready, input, 1: the downstream takes the result.
REQ-013 SHALL have port out_data, output, 128: plaintext.
REQ-014 SHALL have port out_err, output, 1: qualified by out_valid; the job used an illegal or unsupported key_len.

Function
REQ-015 SHALL implement FSM IDLE, ROUND, LAST, DONE.
REQ-016 IDLE: in_ready = 1 and key_idx = NR. On in_valid: state <= in_data ^ key_data, rnd <= NR-1, latch NR, go to ROUND (or to LAST if NR-1 = 0 cannot occur, so ROUND always follows).
REQ-017 ROUND: key_idx = rnd; state <= InvMixColumns(InvSubBytes(InvShiftRows(state)) ^ key_data); rnd decrements; leave for LAST when rnd = 1.
REQ-018 LAST: key_idx = 0; state <= InvSubBytes(InvShiftRows(state)) ^ key_data; go to DONE.
REQ-019 Latency SHALL be NR+1 cycles: out_valid rises in cycle NR+1 after the accept cycle, with accept as cycle 0. This is 11, 13 or 15 cycles.
REQ-020 DONE: out_valid = 1; out_data and out_err SHALL hold stable until out_ready = 1.
REQ-021 DONE with out_ready = 1: if in_valid = 1, the block SHALL accept the new job that same cycle (in_ready = 1) and go to ROUND; otherwise it goes to IDLE. There are no bubbles back-to-back.
REQ-022 in_ready SHALL be 0 in ROUND and LAST, and in DONE while out_ready = 0.
REQ-023 A key_len of 11, or a key_len requiring more than MAX_NR rounds, SHALL run as 10 rounds and set out_err = 1 for that job.
REQ-024 key_idx SHALL be 0 in DONE when no new job is accepted.
REQ-025 in_valid and in_data SHALL be ignored outside accept cycles.
REQ-026 InvMixColumns SHALL use GF(2^8) with polynomial 0x11B and coefficients 0e, 0b, 0d, 09.

Reset
REQ-027 rst = 0 SHALL immediately force IDLE, state = 0, rnd = 0, out_valid = 0, out_err = 0, out_data = 0, and in_ready = 1 after release.
REQ-028 Reset mid-job SHALL discard the job with no output.
REQ-029 The first accept SHALL be possible on the first rising edge with rst = 1.

Structure
REQ-030 Shared package aes_pkg SHALL hold: the state typedef (4x4 bytes), NR constants 10/12/14, key_len encodings, the inverse S-box table or function, and the xtime/gmul function.
REQ-031 One sub-module, inv_round_comb, SHALL be combinational with inputs state, key and a mix_en flag (low for the last round). It performs InvShiftRows, InvSubBytes, AddRoundKey, then InvMixColumns when mix_en is high.
REQ-032 The FSM, rnd counter and handshake SHALL live in inv_cipher_iter.

Verification
REQ-033 AES-128: key 000102..0f, ct 69c4e0d86a7b0430d8cdb78070b4c55a, key_len 00 -> pt 00112233445566778899aabbccddeeff; key_idx sequence 10,9..0; out_valid in cycle 11; out_err 0.
REQ-034 AES-192: key 000102..17, ct dda97ca4864cdfe06eaf70a0ec0d7191, key_len 01 -> the same pt, out_valid in cycle 13.
REQ-035 AES-256: key 000102..1f, ct 8ea2b7ca516745bfeafc49904b496089, key_len 10 -> the same pt, out_valid in cycle 15.
REQ-036 Backpressure and back-to-back: hold out_ready = 0 for 5 cycles -> out_data stable and in_ready = 0; then out_ready = 1 with in_valid = 1 -> the second job is accepted in the same cycle and its result arrives 11 cycles later.
REQ-037 Reset mid-job: drop rst at cycle 5 of an AES-128 job -> out_valid stays 0 and all outputs are 0. Then run the REQ-033 vector -> correct pt.
REQ-038 Illegal mode: key_len 11 with the REQ-033 vector -> pt 00112233..ff, out_err = 1 and 11-cycle latency. Next legal job -> out_err = 0.
